data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 149 ++++++++++++++
 tb/tb_data_sram_resp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// Data SRAM with an in-order response queue: one load/store accepted per cycle,
// each answered by a single registered data_ok pulse LATENCY cycles later.
module data_sram_resp #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned WORDS     = 1 << MEM_AW;
  localparam logic [2:0]  CNT_MAX   = 3'(QDEPTH);
  localparam logic [1:0]  PTR_LAST  = 2'(QDEPTH - 1);
  // The accepting edge already counts toward LATENCY, so an entry waits LATENCY-2
  // more edges and retires on the edge after its counter reaches zero.
  localparam logic [2:0]  WAIT_INIT = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam bit          BYPASS    = (LATENCY == 1);

  logic [31:0] mem_q [WORDS];

  logic [2:0]  count_q, count_d;
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  cnt_q  [4];
  logic [2:0]  cnt_d  [4];
  logic [31:0] snap_q [4];
  logic [31:0] snap_d [4];
  logic [3:0]  mis_q, mis_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic              accept;
  logic              push;
  logic              head_ret;
  logic              mis;
  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;
  logic [31:0]       entry_data;
  logic              unused_addr_hi;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign addr_ok        = !reset && (count_q < CNT_MAX);
  assign accept         = req && addr_ok;
  assign push           = accept && !BYPASS;
  assign idx            = addr[MEM_AW+1:2];
  assign unused_addr_hi = ^addr[31:MEM_AW+2];
  assign rd_word        = mem_q[idx];
  assign mis            = (size == 2'd3)
                       || ((size == 2'd1) && addr[0])
                       || ((size == 2'd2) && (addr[1:0] != 2'b00));
  assign entry_data     = (!wr && !mis) ? rd_word : '0;
  assign head_ret       = (count_q != '0) && (cnt_q[rptr_q] == '0);

  always_comb begin
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    mis_d     = mis_q;
    data_ok_d = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;

    for (int unsigned i = 0; i < 4; i++) begin
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 3'd1;
    end

    if (head_ret) begin
      data_ok_d = 1'b1;
      rdata_d   = snap_q[rptr_q];
      err_d     = mis_q[rptr_q];
      rptr_d    = ptr_inc(rptr_q);
    end

    // With LATENCY=1 the request answers on its own accepting edge and never queues.
    if (accept && BYPASS) begin
      data_ok_d = 1'b1;
      rdata_d   = entry_data;
      err_d     = mis;
    end

    if (push) begin
      cnt_d[wptr_q]  = WAIT_INIT;
      snap_d[wptr_q] = entry_data;
      mis_d[wptr_q]  = mis;
      wptr_d         = ptr_inc(wptr_q);
    end

    unique case ({push, head_ret})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '{default: '0};
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    mis_q  <= mis_d;
  end

  always_ff @(posedge clk) begin
    if (accept && wr && !mis) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: three instances (LATENCY 2, 4 and 1)
// driven on the falling edge and sampled on the falling edge.
module tb_data_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_req, a_wr, a_aok, a_dok, a_err;
  logic [1:0]  a_size;
  logic [3:0]  a_strb;
  logic [31:0] a_addr, a_wdata, a_rdata;

  logic        b_req, b_wr, b_aok, b_dok, b_err;
  logic [1:0]  b_size;
  logic [3:0]  b_strb;
  logic [31:0] b_addr, b_wdata, b_rdata;

  logic        c_req, c_wr, c_aok, c_dok, c_err;
  logic [1:0]  c_size;
  logic [3:0]  c_strb;
  logic [31:0] c_addr, c_wdata, c_rdata;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  data_sram_resp #(.MEM_AW(10), .LATENCY(2), .QDEPTH(2)) u_a (
    .clk(clk), .reset(reset), .req(a_req), .wr(a_wr), .size(a_size), .wstrb(a_strb),
    .addr(a_addr), .wdata(a_wdata), .addr_ok(a_aok), .data_ok(a_dok), .rdata(a_rdata), .err(a_err)
  );

  data_sram_resp #(.MEM_AW(10), .LATENCY(4), .QDEPTH(2)) u_b (
    .clk(clk), .reset(reset), .req(b_req), .wr(b_wr), .size(b_size), .wstrb(b_strb),
    .addr(b_addr), .wdata(b_wdata), .addr_ok(b_aok), .data_ok(b_dok), .rdata(b_rdata), .err(b_err)
  );

  data_sram_resp #(.MEM_AW(10), .LATENCY(1), .QDEPTH(2)) u_c (
    .clk(clk), .reset(reset), .req(c_req), .wr(c_wr), .size(c_size), .wstrb(c_strb),
    .addr(c_addr), .wdata(c_wdata), .addr_ok(c_aok), .data_ok(c_dok), .rdata(c_rdata), .err(c_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic a_drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] ad, input logic [31:0] wd);
    a_req = r; a_wr = w; a_size = sz; a_strb = st; a_addr = ad; a_wdata = wd;
  endtask

  task automatic b_drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] ad, input logic [31:0] wd);
    b_req = r; b_wr = w; b_size = sz; b_strb = st; b_addr = ad; b_wdata = wd;
  endtask

  task automatic c_drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] ad, input logic [31:0] wd);
    c_req = r; c_wr = w; c_size = sz; c_strb = st; c_addr = ad; c_wdata = wd;
  endtask

  // One isolated request on u_a; response expected exactly two cycles on.
  task automatic a_single(input string tag, input logic w, input logic [1:0] sz,
                          input logic [3:0] st, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    a_drive(1'b1, w, sz, st, ad, wd);
    chk({tag, ".aok"}, 32'(a_aok), 32'd1);
    @(negedge clk);
    a_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    chk({tag, ".early"}, 32'(a_dok), 32'd0);
    @(negedge clk);
    chk({tag, ".dok"}, 32'(a_dok), 32'd1);
    chk({tag, ".rdata"}, a_rdata, exp_rd);
    chk({tag, ".err"}, 32'(a_err), 32'(exp_err));
  endtask

  logic [31:0] v_addr [4];
  logic [1:0]  v_size [4];
  logic [31:0] v_exp  [4];
  logic        t_aok  [5];
  logic        t_dok  [9];
  logic [31:0] t_rd   [9];
  logic        t_err  [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    b_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    c_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst.aok", 32'(a_aok), 32'd0);
    chk("rst.dok", 32'(a_dok), 32'd0);
    chk("rst.rdata", a_rdata, 32'h0);
    chk("rst.err", 32'(a_err), 32'd0);
    chk("rst.b_aok", 32'(b_aok), 32'd0);
    chk("rst.c_aok", 32'(c_aok), 32'd0);
    reset = 1'b0;

    a_single("st_word",      1'b1, 2'd2, 4'hF,    32'h0000_0100, 32'h1122_3344, 32'h0,         1'b0);
    a_single("ld_word",      1'b0, 2'd2, 4'h0,    32'h0000_0100, 32'h0,         32'h1122_3344, 1'b0);
    a_single("st_byte",      1'b1, 2'd0, 4'b0010, 32'h0000_0101, 32'h0000_AB00, 32'h0,         1'b0);
    a_single("ld_merge",     1'b0, 2'd2, 4'h0,    32'h0000_0100, 32'h0,         32'h1122_AB44, 1'b0);
    a_single("ld_half_mis",  1'b0, 2'd1, 4'h0,    32'h0000_0103, 32'h0,         32'h0,         1'b1);
    a_single("st_word_mis",  1'b1, 2'd2, 4'hF,    32'h0000_0102, 32'hDEAD_BEEF, 32'h0,         1'b1);
    a_single("ld_after_mis", 1'b0, 2'd2, 4'h0,    32'h0000_0100, 32'h0,         32'h1122_AB44, 1'b0);
    a_single("ld_rsvd",      1'b0, 2'd3, 4'h0,    32'h0000_0100, 32'h0,         32'h0,         1'b1);
    a_single("st_wrap",      1'b1, 2'd2, 4'hF,    32'hFFFF_F104, 32'hCAFE_F00D, 32'h0,         1'b0);
    a_single("ld_wrap",      1'b0, 2'd2, 4'h0,    32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1'b0);
    a_single("st_nostrb",    1'b1, 2'd2, 4'h0,    32'h0000_0104, 32'h0,         32'h0,         1'b0);
    a_single("st_half",      1'b1, 2'd1, 4'b1100, 32'h0000_0106, 32'h1234_0000, 32'h0,         1'b0);
    a_single("ld_half_mrg",  1'b0, 2'd2, 4'h0,    32'h8000_0104, 32'h0,         32'h1234_F00D, 1'b0);

    // Load snapshot must not see a store accepted one cycle later.
    @(negedge clk);
    a_drive(1'b1, 1'b0, 2'd2, 4'h0, 32'h0000_0104, 32'h0);
    chk("snap.aok0", 32'(a_aok), 32'd1);
    @(negedge clk);
    a_drive(1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_0104, 32'h5555_5555);
    chk("snap.aok1", 32'(a_aok), 32'd1);
    chk("snap.early", 32'(a_dok), 32'd0);
    @(negedge clk);
    a_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    chk("snap.dok0", 32'(a_dok), 32'd1);
    chk("snap.rd0", a_rdata, 32'h1234_F00D);
    @(negedge clk);
    chk("snap.dok1", 32'(a_dok), 32'd1);
    chk("snap.rd1", a_rdata, 32'h0);
    @(negedge clk);
    chk("snap.idle", 32'(a_dok), 32'd0);
    a_single("ld_new", 1'b0, 2'd2, 4'h0, 32'h0000_0104, 32'h0, 32'h5555_5555, 1'b0);

    // Four back-to-back loads with req held high.
    v_addr = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0103, 32'h0000_0106};
    v_size = '{2'd2, 2'd2, 2'd0, 2'd1};
    v_exp  = '{32'h1122_AB44, 32'h5555_5555, 32'h1122_AB44, 32'h5555_5555};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("b2b.dok", 32'(a_dok), 32'd1);
        chk("b2b.rdata", a_rdata, v_exp[i-2]);
      end else begin
        chk("b2b.early", 32'(a_dok), 32'd0);
      end
      if (i < 4) begin
        a_drive(1'b1, 1'b0, v_size[i], 4'h0, v_addr[i], 32'h0);
        chk("b2b.aok", 32'(a_aok), 32'd1);
      end else begin
        a_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      end
    end
    @(negedge clk);
    chk("b2b.tail", 32'(a_dok), 32'd0);

    // LATENCY=4, QDEPTH=2: third request stalls until the first retires.
    t_aok = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t_dok = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t_rd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0};
    t_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("full.dok", 32'(b_dok), 32'(t_dok[i]));
      chk("full.rdata", b_rdata, t_rd[i]);
      chk("full.err", 32'(b_err), 32'(t_err[i]));
      if (i == 0)      b_drive(1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_0000, 32'hA5A5_A5A5);
      else if (i == 1) b_drive(1'b1, 1'b0, 2'd2, 4'h0, 32'h0000_0000, 32'h0);
      else if (i < 5)  b_drive(1'b1, 1'b0, 2'd2, 4'h0, 32'h0000_0001, 32'h0);
      else             b_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      if (i < 5) chk("full.aok", 32'(b_aok), 32'(t_aok[i]));
    end

    // LATENCY=1: response in the cycle right after acceptance.
    @(negedge clk);
    c_drive(1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_0200, 32'h0102_0304);
    chk("l1.aok0", 32'(c_aok), 32'd1);
    @(negedge clk);
    chk("l1.dok0", 32'(c_dok), 32'd1);
    chk("l1.rd0", c_rdata, 32'h0);
    c_drive(1'b1, 1'b0, 2'd2, 4'h0, 32'h0000_0200, 32'h0);
    chk("l1.aok1", 32'(c_aok), 32'd1);
    @(negedge clk);
    chk("l1.dok1", 32'(c_dok), 32'd1);
    chk("l1.rd1", c_rdata, 32'h0102_0304);
    c_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("l1.idle", 32'(c_dok), 32'd0);

    // Reset one cycle after a load is accepted discards it.
    @(negedge clk);
    a_drive(1'b1, 1'b0, 2'd2, 4'h0, 32'h0000_0100, 32'h0);
    chk("mrst.aok", 32'(a_aok), 32'd1);
    @(negedge clk);
    a_drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst.aok_low", 32'(a_aok), 32'd0);
    chk("mrst.dok", 32'(a_dok), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst.aok_up", 32'(a_aok), 32'd1);
    chk("mrst.dok1", 32'(a_dok), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mrst.quiet", 32'(a_dok), 32'd0);
    end
    a_single("ld_post_rst", 1'b0, 2'd2, 4'h0, 32'h0000_0100, 32'h0, 32'h1122_AB44, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
